// File: rtl/bitrev_host.sv
// bitrev_host: initiator for the 4-word bit-reversal wrapper.
// Takes one batch of N_WORDS words from an upstream valid/ready stream,
// writes them into the wrapper with level strobes held and gapped for the
// wrapper's sampling, starts it, reads the reordered words back and
// presents them downstream. Waits out the wrapper's self-reset before the
// next batch. All strobes and handshake outputs are registered.
module bitrev_host #(
    parameter int DATA_W   = 32,
    parameter int N_WORDS  = 4,
    parameter int HOLD_CYC = 2,
    parameter int GAP_CYC  = 2,
    parameter int RD_LAT   = 2,
    parameter int RST_WAIT = 6,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] br_din_o,
    output logic              br_write_o,
    output logic              br_start_o,
    output logic              br_read_o,
    input  logic [DATA_W-1:0] br_dout_i,
    input  logic              br_done_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int PH_MAX_A = (TIMEOUT > RST_WAIT) ? TIMEOUT : RST_WAIT;
    localparam int PH_MAX   = (PH_MAX_A > HOLD_CYC + GAP_CYC) ? PH_MAX_A : HOLD_CYC + GAP_CYC;
    localparam int PH_W     = $clog2(PH_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
    localparam logic [PH_W-1:0]  HOLD_END  = PH_W'(HOLD_CYC - 1);
    localparam logic [PH_W-1:0]  GAP_END   = PH_W'(GAP_CYC - 1);
    localparam logic [PH_W-1:0]  TO_END    = PH_W'(TIMEOUT - 1);
    localparam logic [PH_W-1:0]  RW_END    = PH_W'(RST_WAIT - 1);
    // Capture point: cycle RD_LAT after read rise, either inside the high
    // phase or carried over into the low gap.
    localparam bit               LAT_IN_HI = (RD_LAT < HOLD_CYC);
    localparam logic [PH_W-1:0]  LAT_HI    = PH_W'(RD_LAT);
    localparam logic [PH_W-1:0]  LAT_LO    = PH_W'((RD_LAT >= HOLD_CYC) ? RD_LAT - HOLD_CYC : 0);

    typedef enum logic [3:0] {
        IDLE,
        WR_HI,
        WR_LO,
        START,
        WAIT_DONE,
        RD_HI,
        RD_LO,
        OUT,
        RECOVER,
        ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [PH_W-1:0]  phase_reg, phase_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic             load_word;
    logic             capture;
    logic             s_hs;

    assign s_hs = s_valid_i && s_ready_o;

    // Next-state, phase/index counters and datapath enables
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        index_next = index_reg;
        load_word  = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_hs) begin
                    load_word  = 1'b1;
                    index_next = '0;
                    phase_next = '0;
                    state_next = WR_HI;
                end
            end
            WR_HI: begin
                if (br_done_i) begin
                    state_next = ERR;
                end else if (phase_reg == HOLD_END) begin
                    phase_next = '0;
                    state_next = WR_LO;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            WR_LO: begin
                if (br_done_i) begin
                    state_next = ERR;
                end else if (phase_reg != GAP_END) begin
                    phase_next = phase_reg + 1'b1;
                end else if (index_reg == LAST_IDX) begin
                    phase_next = '0;
                    state_next = START;
                end else if (s_hs) begin
                    load_word  = 1'b1;
                    index_next = index_reg + 1'b1;
                    phase_next = '0;
                    state_next = WR_HI;
                end
            end
            START: begin
                // The start cycle itself counts as cycle 0 of the timeout
                if (br_done_i) begin
                    state_next = ERR;
                end else begin
                    phase_next = PH_W'(1);
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (br_done_i) begin
                    index_next = '0;
                    phase_next = '0;
                    state_next = RD_HI;
                end else if (phase_reg >= TO_END) begin
                    state_next = ERR;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            RD_HI: begin
                capture = LAT_IN_HI && (phase_reg == LAT_HI);
                if (!br_done_i) begin
                    state_next = ERR;
                end else if (phase_reg == HOLD_END) begin
                    phase_next = '0;
                    state_next = RD_LO;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            RD_LO: begin
                capture = !LAT_IN_HI && (phase_reg == LAT_LO);
                if (phase_reg == GAP_END) begin
                    phase_next = '0;
                    state_next = OUT;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            OUT: begin
                if (m_valid_o && m_ready_i) begin
                    phase_next = '0;
                    if (index_reg == LAST_IDX) begin
                        state_next = RECOVER;
                    end else begin
                        index_next = index_reg + 1'b1;
                        state_next = RD_HI;
                    end
                end
            end
            RECOVER: begin
                // Minimum wait first, then also wait for the wrapper to drop done
                if (phase_reg < RW_END) begin
                    phase_next = phase_reg + 1'b1;
                end else if (!br_done_i) begin
                    phase_next = '0;
                    state_next = IDLE;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            phase_reg  <= '0;
            index_reg  <= '0;
            br_din_o   <= '0;
            m_data_o   <= '0;
            br_write_o <= 1'b0;
            br_start_o <= 1'b0;
            br_read_o  <= 1'b0;
            m_valid_o  <= 1'b0;
            m_last_o   <= 1'b0;
            s_ready_o  <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            index_reg  <= index_next;
            if (load_word) begin
                br_din_o <= s_data_i;
            end
            if (capture) begin
                m_data_o <= br_dout_i;
            end
            br_write_o <= (state_next == WR_HI);
            br_start_o <= (state_next == START);
            br_read_o  <= (state_next == RD_HI);
            m_valid_o  <= (state_next == OUT);
            m_last_o   <= (state_next == OUT) && (index_next == LAST_IDX);
            s_ready_o  <= (state_next == IDLE) ||
                          ((state_next == WR_LO) && (phase_next == GAP_END) && (index_next != LAST_IDX));
            busy_o     <= (state_next != IDLE);
            err_o      <= err_o || (state_next == ERR);
        end
    end

endmodule

// File: tb/tb_bitrev_host.sv
// tb_bitrev_host: directed sequence of batches with random data against a
// behavioural wrapper stand-in; expected output order is the input order
// with 2-bit indices reversed.
`timescale 1ns/1ps
module tb_bitrev_host;
    localparam int DW   = 32;
    localparam int NW   = 4;
    localparam int HOLD = 2;
    localparam int GAP  = 2;
    localparam int RSTW = 6;
    localparam int TO   = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic [DW-1:0] br_din;
    logic          br_write, br_start, br_read;
    logic [DW-1:0] br_dout;
    logic          br_done;
    logic          busy, err;

    int n_checks = 0;
    int n_pass   = 0;

    bitrev_host dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid_i  (s_valid),
        .s_data_i   (s_data),
        .s_ready_o  (s_ready),
        .m_valid_o  (m_valid),
        .m_data_o   (m_data),
        .m_last_o   (m_last),
        .m_ready_i  (m_ready),
        .br_din_o   (br_din),
        .br_write_o (br_write),
        .br_start_o (br_start),
        .br_read_o  (br_read),
        .br_dout_i  (br_dout),
        .br_done_i  (br_done),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    function automatic int bitrev(input int i);
        return ((i & 1) << 1) | ((i >> 1) & 1);
    endfunction

    // Wrapper stand-in: stores writes in order, returns reversed-index order
    logic [DW-1:0] mdl_mem [NW];
    logic          wr_q, rd_q, mdl_done;
    logic [DW-1:0] mdl_dout;
    int            wptr, rptr, done_dly, rst_cnt;
    int            n_wr = 0, n_rd = 0, n_st = 0;
    bit            done_en = 1'b1;
    int            rst_len = 4;

    assign br_dout = mdl_dout;
    assign br_done = mdl_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= 1'b0; rd_q <= 1'b0; mdl_done <= 1'b0; mdl_dout <= '0;
            wptr <= 0; rptr <= 0; done_dly <= 0; rst_cnt <= 0;
        end else begin
            wr_q <= br_write;
            rd_q <= br_read;
            if (br_write && !wr_q) begin
                mdl_mem[wptr % NW] <= br_din;
                wptr <= wptr + 1;
                n_wr <= n_wr + 1;
            end
            if (br_start) begin
                n_st <= n_st + 1;
                if (done_en) done_dly <= 3;
            end
            if (done_dly > 0) begin
                done_dly <= done_dly - 1;
                if (done_dly == 1) mdl_done <= 1'b1;
            end
            if (br_read && !rd_q) begin
                mdl_dout <= mdl_mem[bitrev(rptr % NW)];
                rptr <= rptr + 1;
                n_rd <= n_rd + 1;
            end
            if (!br_read && rd_q && rptr == NW) rst_cnt <= rst_len;
            if (rst_cnt > 0) begin
                rst_cnt <= rst_cnt - 1;
                if (rst_cnt == 1) begin
                    mdl_done <= 1'b0; wptr <= 0; rptr <= 0;
                end
            end
        end
    end

    // Strobe/handshake monitor sampled mid-cycle; violations tallied for later checks
    int            cyc = 0;
    int            w_run = 100, r_run = 100, s_run = 100;
    logic          w_prev = 1'b0, r_prev = 1'b0, s_prev = 1'b0;
    logic          err_prev = 1'b0, done_prev = 1'b0, rdy_prev = 1'b0, stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    int            bad_w = 0, bad_r = 0, bad_s = 0, bad_excl = 0, bad_rdv = 0;
    int            bad_stable = 0, bad_start_pos = 0;
    int            start_cyc = 0, err_cyc = 0, rd_fall_cyc = 0, done_fall_cyc = 0;
    int            rdy_rise_cyc = 0, wr_at_start = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            w_prev <= 1'b0; r_prev <= 1'b0; s_prev <= 1'b0;
            w_run <= 100; r_run <= 100; s_run <= 100;
            err_prev <= 1'b0; done_prev <= 1'b0; rdy_prev <= 1'b0; stall_prev <= 1'b0;
        end else begin
            w_prev <= br_write; r_prev <= br_read; s_prev <= br_start;
            if (br_write != w_prev) begin
                w_run <= 1;
                if (w_prev && w_run != HOLD) bad_w <= bad_w + 1;
                if (!w_prev && w_run < GAP) bad_w <= bad_w + 1;
            end else w_run <= w_run + 1;
            if (br_read != r_prev) begin
                r_run <= 1;
                if (r_prev && r_run != HOLD) bad_r <= bad_r + 1;
                if (!r_prev && r_run < GAP) bad_r <= bad_r + 1;
            end else r_run <= r_run + 1;
            if (br_start != s_prev) begin
                s_run <= 1;
                if (s_prev && s_run != 1) bad_s <= bad_s + 1;
            end else s_run <= s_run + 1;
            if (br_start && !s_prev) begin
                start_cyc   <= cyc;
                wr_at_start <= n_wr;
                if (br_write || w_run != GAP) bad_start_pos <= bad_start_pos + 1;
            end
            if (int'(br_write) + int'(br_read) + int'(br_start) > 1) bad_excl <= bad_excl + 1;
            if (br_read && m_valid) bad_rdv <= bad_rdv + 1;
            stall_prev <= m_valid && !m_ready;
            data_prev  <= m_data;
            if (stall_prev && m_data != data_prev) bad_stable <= bad_stable + 1;
            err_prev <= err;
            if (err && !err_prev) err_cyc <= cyc;
            if (!br_read && r_prev) rd_fall_cyc <= cyc;
            done_prev <= br_done;
            if (!br_done && done_prev) done_fall_cyc <= cyc;
            rdy_prev <= s_ready;
            if (s_ready && !rdy_prev) rdy_rise_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks = n_checks + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    logic [DW-1:0] words [NW];

    task automatic fill_random();
        for (int i = 0; i < NW; i++) words[i] = $urandom;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_ready && t < 200);
        check("send_ready", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        $display("send word 0x%08h", d);
    endtask

    task automatic send_batch(input int stall_len);
        for (int i = 0; i < NW; i++) begin
            send(words[i]);
            if (i == 0 && stall_len > 0) begin
                repeat (stall_len) @(posedge clk);
                #1;
                check("stall_write_low", br_write, 0);
                check("stall_ready_wait", s_ready, 1);
            end
        end
    endtask

    task automatic recv_batch(input int bp_word, input int bp_len, input int n_words);
        for (int i = 0; i < n_words; i++) begin
            int t;
            logic [DW-1:0] exp_word;
            exp_word = words[bitrev(i)];
            if (i == bp_word) m_ready = 1'b0;
            t = 0;
            do begin @(negedge clk); t++; end while (!m_valid && t < 300);
            check("out_valid", m_valid, 1);
            if (i == bp_word) begin
                repeat (bp_len) @(negedge clk);
                check("bp_valid_held", m_valid, 1);
                @(posedge clk); #1;
                m_ready = 1'b1;
                @(negedge clk);
            end
            check("out_data", m_data, exp_word);
            check("out_last", m_last, (i == NW - 1));
            $display("recv word %0d data 0x%08h last %0b", i, m_data, m_last);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_batch(input int stall_len, input int bp_word, input int bp_len);
        int wr0, rd0, st0;
        wr0 = n_wr; rd0 = n_rd; st0 = n_st;
        send_batch(stall_len);
        recv_batch(bp_word, bp_len, NW);
        check("n_writes", n_wr - wr0, NW);
        check("n_starts", n_st - st0, 1);
        check("n_reads", n_rd - rd0, NW);
        check("writes_before_start", wr_at_start - wr0, NW);
    endtask

    task automatic wait_ready_and_check_recovery();
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_ready && t < 200);
        check("recover_ready", s_ready, 1);
        @(negedge clk);
        check("recover_after_read", (rdy_rise_cyc - rd_fall_cyc) >= RSTW, 1);
        check("recover_after_done", rdy_rise_cyc > done_fall_cyc, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {s_ready, m_valid, m_last, br_write, br_start, br_read, busy, err}, 0);
        check("rst_m_data", m_data, 0);
        check("rst_din", br_din, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", s_ready, 1);
        check("idle_busy", busy, 0);

        // Basic batch with the fixed words
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        words[2] = 32'h33333333; words[3] = 32'h44444444;
        run_batch(0, -1, 0);
        check("strobe_write_timing", bad_w, 0);
        check("strobe_read_timing", bad_r, 0);
        check("strobe_start_width", bad_s, 0);
        check("start_after_gap", bad_start_pos, 0);
        check("strobe_exclusive", bad_excl, 0);
        wait_ready_and_check_recovery();

        // Backpressure on word 2
        fill_random();
        run_batch(0, 1, 10);
        check("bp_data_stable", bad_stable, 0);
        check("bp_no_read_while_valid", bad_rdv, 0);
        wait_ready_and_check_recovery();

        // Upstream stall after word 1
        fill_random();
        run_batch(7, -1, 0);
        check("stall_write_timing", bad_w, 0);
        wait_ready_and_check_recovery();

        // Back-to-back batches with a slow wrapper self-reset
        rst_len = 15;
        fill_random();
        run_batch(0, -1, 0);
        wait_ready_and_check_recovery();
        fill_random();
        run_batch(0, -1, 0);
        wait_ready_and_check_recovery();
        rst_len = 4;

        // Timeout: wrapper never raises done
        done_en = 1'b0;
        fill_random();
        send_batch(0);
        t = 0;
        do begin @(negedge clk); t++; end while (!err && t < 1200);
        check("timeout_err", err, 1);
        @(negedge clk);
        check("timeout_cycles", err_cyc - start_cyc, TO);
        repeat (5) @(negedge clk);
        check("err_strobes_low", {br_write, br_start, br_read, s_ready, m_valid}, 0);
        check("err_sticky", {err, busy}, 2'b11);
        $display("timeout err after %0d cycles", err_cyc - start_cyc);
        #2;
        reset = 1'b1;
        #1;
        check("err_cleared_by_reset", err, 0);
        done_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of the read phase
        fill_random();
        send_batch(0);
        recv_batch(-1, 0, 1);
        t = 0;
        do begin @(negedge clk); t++; end while (!br_read && t < 100);
        check("midread_read_seen", br_read, 1);
        #2;
        reset = 1'b1;
        #1;
        check("midread_flags", {s_ready, m_valid, m_last, br_write, br_start, br_read, busy, err}, 0);
        check("midread_m_data", m_data, 0);
        check("midread_din", br_din, 0);
        $display("reset asserted mid-read");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        fill_random();
        run_batch(0, -1, 0);
        check("final_no_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
